// File: rtl/gate_alu_pkg.sv
// Shared opcode constants and sweep sequencer state encoding for the gate ALU.
// Imported by the core, the registered top and the bench.
package gate_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/gate_alu_reg_if.sv
// Operand/result stream bundle of the gate ALU plus its sweep control strobes.
// slave is the ALU side, master is the stimulus/checker side.
interface gate_alu_reg_if #(
  parameter int WIDTH = 4
);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Inp_1;
  logic [WIDTH-1:0] Inp_2;
  logic [2:0]       Op;
  logic             Sweep_start;
  logic [WIDTH-1:0] Outp;
  logic [WIDTH-1:0] Outp_a;
  logic [WIDTH-1:0] Outp_b;
  logic             Out_valid;
  logic             Out_ready;
  logic             Sweep_busy;
  logic             Sweep_done;

  modport master (
    output In_valid, Inp_1, Inp_2, Op, Sweep_start, Out_ready,
    input  In_ready, Outp, Outp_a, Outp_b, Out_valid, Sweep_busy, Sweep_done
  );

  modport slave (
    input  In_valid, Inp_1, Inp_2, Op, Sweep_start, Out_ready,
    output In_ready, Outp, Outp_a, Outp_b, Out_valid, Sweep_busy, Sweep_done
  );
endinterface

// File: rtl/gate_alu_core.sv
// Combinational bitwise logic unit: eight operations over WIDTH bits.
// Zero latency, no flow control of its own.
module gate_alu_core
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] Inp_1,
  input  logic [WIDTH-1:0] Inp_2,
  input  logic [2:0]       Op,
  output logic [WIDTH-1:0] Outp
);

  always_comb begin
    Outp = Inp_1;
    case (Op)
      OP_AND:  Outp = Inp_1 & Inp_2;
      OP_NAND: Outp = ~(Inp_1 & Inp_2);
      OP_OR:   Outp = Inp_1 | Inp_2;
      OP_NOR:  Outp = ~(Inp_1 | Inp_2);
      OP_XOR:  Outp = Inp_1 ^ Inp_2;
      OP_XNOR: Outp = ~(Inp_1 ^ Inp_2);
      OP_NOT:  Outp = ~Inp_1;
      OP_PASS: Outp = Inp_1;
      default: Outp = Inp_1;
    endcase
  end

endmodule

// File: rtl/gate_alu_reg.sv
// Registered gate ALU with exhaustive operand sweep; one cycle accept-to-result latency.
// Single output register stalls in place while Out_valid && !Out_ready; In_ready drops with it.
module gate_alu_reg
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  gate_alu_reg_if.slave  bus
);

  localparam int CW = 2 * WIDTH;

  sweep_state_t     state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       sweep_op;

  logic             out_valid_q;
  logic [WIDTH-1:0] outp_q, outp_a_q, outp_b_q;
  logic             done_q;

  logic             load, busy, issue, sweep_arm, cnt_inc, done_nxt;
  logic [WIDTH-1:0] src_a, src_b, res;
  logic [2:0]       src_op;

  assign busy = (state != IDLE);
  assign load = !out_valid_q || bus.Out_ready;

  // Sweep counter owns the datapath for the whole sweep, external port only when idle.
  assign src_a  = busy ? cnt[WIDTH-1:0]  : bus.Inp_1;
  assign src_b  = busy ? cnt[CW-1:WIDTH] : bus.Inp_2;
  assign src_op = busy ? sweep_op        : bus.Op;

  gate_alu_core #(.WIDTH(WIDTH)) u_core (
    .Inp_1 (src_a),
    .Inp_2 (src_b),
    .Op    (src_op),
    .Outp  (res)
  );

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    sweep_arm = 1'b0;
    cnt_inc   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        issue = bus.In_valid && load;
        if (bus.Sweep_start) begin
          state_nxt = SWEEP;
          sweep_arm = 1'b1;
        end
      end
      SWEEP: begin
        if (load) begin
          issue = 1'b1;
          // All-ones is the last operand pair; counter parks there instead of wrapping.
          if (&cnt) state_nxt = DRAIN;
          else      cnt_inc   = 1'b1;
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.Out_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sweep_op <= OP_AND;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (sweep_arm) begin
        cnt      <= '0;
        sweep_op <= bus.Op;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      outp_q      <= '0;
      outp_a_q    <= '0;
      outp_b_q    <= '0;
    end else if (load) begin
      out_valid_q <= issue;
      if (issue) begin
        outp_q   <= res;
        outp_a_q <= src_a;
        outp_b_q <= src_b;
      end
    end
  end

  assign bus.In_ready   = load && !busy;
  assign bus.Out_valid  = out_valid_q;
  assign bus.Outp       = outp_q;
  assign bus.Outp_a     = outp_a_q;
  assign bus.Outp_b     = outp_b_q;
  assign bus.Sweep_busy = busy;
  assign bus.Sweep_done = done_q;

endmodule

// File: tb/tb_gate_alu_reg.sv
// Self-checking bench for gate_alu_reg: directed op table, back-pressure, randomized sweep, reset mid-sweep.
// A transaction-level model tracks the output slot and sweep progress and is compared every cycle.
module tb_gate_alu_reg;
  import gate_alu_pkg::*;

  localparam int W  = 4;
  localparam int NB = 1 << (2 * W);

  logic clk;
  logic rst;

  gate_alu_reg_if #(.WIDTH(W)) bus ();

  gate_alu_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // Reference model state: contents of the single output slot and sweep progress.
  bit          chk_en = 1'b0;
  bit          m_ov, m_act, m_done, m_sw;
  bit [W-1:0]  m_a, m_b, m_r;
  bit [2:0]    m_sop;
  int          m_iss = 0;
  int          sw_xfers = 0;
  int          done_cnt = 0;
  bit          mv_load, mv_xfer, mv_iss, mv_sw, mv_nd;
  bit [W-1:0]  mv_a, mv_b;
  bit [2:0]    mv_op;

  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      check("cycle", {bus.Out_valid, bus.Outp, bus.Outp_a, bus.Outp_b,
                      bus.Sweep_busy, bus.Sweep_done, bus.In_ready},
                     {m_ov, m_r, m_a, m_b, m_act, m_done,
                      (!m_ov || bus.Out_ready) && !m_act});
    end
    if (bus.Sweep_done === 1'b1) done_cnt++;
    if (rst) begin
      m_ov = 0; m_act = 0; m_done = 0; m_sw = 0;
      m_a = '0; m_b = '0; m_r = '0; m_iss = 0; sw_xfers = 0;
      chk_en = 1'b1;
    end else begin
      mv_load = !m_ov || bus.Out_ready;
      mv_xfer = m_ov && bus.Out_ready;
      mv_iss  = 0;
      mv_sw   = 0;
      mv_a    = '0;
      mv_b    = '0;
      mv_op   = '0;
      if (mv_xfer && m_sw) sw_xfers++;
      mv_nd = m_act && (m_iss == NB) && mv_xfer;
      if (!m_act) begin
        if (bus.In_valid && mv_load) begin
          mv_iss = 1; mv_a = bus.Inp_1; mv_b = bus.Inp_2; mv_op = bus.Op;
        end
        if (bus.Sweep_start) begin
          m_act = 1; m_sop = bus.Op; m_iss = 0; sw_xfers = 0;
        end
      end else if (m_iss < NB && mv_load) begin
        // Sweep beat n carries A = n mod 2^W, B = n div 2^W.
        mv_iss = 1; mv_sw = 1;
        mv_a = W'(m_iss % (1 << W));
        mv_b = W'(m_iss / (1 << W));
        mv_op = m_sop;
        m_iss++;
      end
      if (mv_load) begin
        m_ov = mv_iss;
        m_sw = mv_sw;
        if (mv_iss) begin
          m_a = mv_a; m_b = mv_b; m_r = ref_op(mv_op, mv_a, mv_b);
        end
      end
      m_done = mv_nd;
      if (mv_nd) m_act = 0;
    end
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[8];
  bit   seen;
  int   d0, cyc;

  initial begin
    tbl[0] = '{OP_AND,  4'b1100, 4'b1010, 4'b1000};
    tbl[1] = '{OP_NAND, 4'b1100, 4'b1010, 4'b0111};
    tbl[2] = '{OP_OR,   4'b1100, 4'b1010, 4'b1110};
    tbl[3] = '{OP_NOR,  4'b1100, 4'b1010, 4'b0001};
    tbl[4] = '{OP_XOR,  4'b1100, 4'b1010, 4'b0110};
    tbl[5] = '{OP_XNOR, 4'b1100, 4'b1010, 4'b1001};
    tbl[6] = '{OP_NOT,  4'b1100, 4'b1010, 4'b0011};
    tbl[7] = '{OP_PASS, 4'b1100, 4'b1010, 4'b1100};

    rst = 1'b1;
    bus.In_valid = 0; bus.Inp_1 = '0; bus.Inp_2 = '0; bus.Op = '0;
    bus.Sweep_start = 0; bus.Out_ready = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid",  bus.Out_valid, 0);
    check("rst_outp",       bus.Outp, 0);
    check("rst_outp_a",     bus.Outp_a, 0);
    check("rst_outp_b",     bus.Outp_b, 0);
    check("rst_sweep_busy", bus.Sweep_busy, 0);
    check("rst_sweep_done", bus.Sweep_done, 0);
    check("rst_in_ready",   bus.In_ready, 1);

    // Directed ops, back-to-back, result one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      bus.In_valid = 1; bus.Op = tbl[i].op; bus.Inp_1 = tbl[i].a; bus.Inp_2 = tbl[i].b;
      @(negedge clk);
      check($sformatf("op%0d_outp", tbl[i].op), bus.Outp, tbl[i].exp);
      check($sformatf("op%0d_valid", tbl[i].op), bus.Out_valid, 1);
    end
    bus.In_valid = 0;
    @(negedge clk);

    // Back-pressure: hold AND result 8 for 5 cycles with the next beat waiting.
    bus.Out_ready = 0; bus.In_valid = 1; bus.Op = OP_AND; bus.Inp_1 = 4'hC; bus.Inp_2 = 4'hA;
    @(negedge clk);
    bus.Op = OP_OR; bus.Inp_1 = 4'h3; bus.Inp_2 = 4'h4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", bus.In_ready, 0);
      check("bp_outp",     bus.Outp, 4'h8);
      check("bp_outp_ab",  {bus.Outp_a, bus.Outp_b}, 8'hCA);
    end
    bus.Out_ready = 1;
    #1;
    check("bp_release_in_ready", bus.In_ready, 1);
    @(negedge clk);
    check("bp_next_outp", bus.Outp, 4'h7);
    bus.In_valid = 0;
    @(negedge clk);

    // XOR sweep with an external beat accepted alongside the start, random stall and noise.
    bus.Op = OP_XOR; bus.Sweep_start = 1; bus.In_valid = 1; bus.Inp_1 = 4'h5; bus.Inp_2 = 4'h9;
    @(negedge clk);
    bus.Sweep_start = 0; bus.In_valid = 0;
    d0 = done_cnt;
    seen = 0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      bus.Out_ready = 1'($urandom_range(0, 1));
      if (m_iss < NB) begin
        bus.In_valid    = 1'($urandom_range(0, 1));
        bus.Sweep_start = ($urandom_range(0, 7) == 0);
        bus.Op          = 3'($urandom_range(0, 7));
        bus.Inp_1       = W'($urandom);
        bus.Inp_2       = W'($urandom);
      end else begin
        bus.In_valid = 0; bus.Sweep_start = 0;
      end
      @(negedge clk);
      if (bus.Sweep_done === 1'b1) seen = 1;
    end
    check("sweep_done_seen", 32'(seen), 1);
    check("sweep_beats", sw_xfers, NB);
    bus.Out_ready = 1; bus.In_valid = 0; bus.Sweep_start = 0;
    repeat (3) @(negedge clk);
    check("sweep_done_once", done_cnt - d0, 1);

    // Reset after the 7th sweep beat has transferred.
    bus.Op = OP_AND; bus.Sweep_start = 1;
    @(negedge clk);
    bus.Sweep_start = 0;
    for (int c = 0; c < 100 && sw_xfers < 7; c++) @(negedge clk);
    check("rst_sweep_reached_beat7", sw_xfers, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid",  bus.Out_valid, 0);
    check("midrst_sweep_busy", bus.Sweep_busy, 0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);

    // Fresh sweep restarts at A=0,B=0 and runs at one beat per cycle.
    bus.Op = OP_OR; bus.Sweep_start = 1;
    @(negedge clk);
    bus.Sweep_start = 0;
    @(negedge clk);
    check("restart_first_valid", bus.Out_valid, 1);
    check("restart_first_ab", {bus.Outp_a, bus.Outp_b}, 8'h00);
    cyc = 2;
    seen = 0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.Sweep_done === 1'b1) seen = 1;
    end
    check("restart_done_cycle", cyc, NB + 2);
    check("restart_beats", sw_xfers, NB);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
